key_event_decoder: RTL
======================

Name: key_event_decoder

Overview:
Consumes the debounced key level from the button debouncer (1 = released, 0 = pressed) and classifies it into discrete gesture events: short press, double click, long press and auto-repeat. Events go out one at a time through a single-entry valid/ready register to the application FSM, such as a display mode controller. All timing comes from an internal millisecond tick enable. No derived clocks are used.

Parameters:
F_CLK, 50000000, system clock frequency in Hz
F_TICK, 1000, timing tick frequency in Hz; tick period = F_CLK/F_TICK clk cycles
LONG_MS, 1000, hold time in ticks before LONG is issued
DCLICK_MS, 250, maximum release gap in ticks for a second press to count as DOUBLE
REPEAT_MS, 100, REPEAT period in ticks while held after LONG

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_state  in  1  debounced key level from the debouncer; 1 = released, 0 = pressed; asynchronous to clk
evt_ready  in  1  consumer accepts the event when high together with evt_valid
ovf_clr  in  1  synchronous clear of ovf
evt_valid  out  1  event register holds a pending event
evt_code  out  3  event code: 1 SHORT, 2 DOUBLE, 3 LONG, 4 REPEAT; 0 when idle
key_pressed  out  1  synchronised pressed level, equal to ~key_s2
ovf  out  1  sticky flag: an event was dropped

Behaviour:
- Reset (async, rst_n=0):
  - Sync flops key_s1, key_s2, key_s3 reset to 1 (released).
  - FSM goes to IDLE; ms_cnt=0; prescaler=0.
  - evt_valid=0, evt_code=0, ovf=0, key_pressed=0.
  - Asserting reset mid-gesture abandons the gesture with no event.
- Input path: key_state → key_s1 → key_s2 → key_s3.
  - press = key_s3 & ~key_s2; release = ~key_s3 & key_s2.
- Tick generation:
  - Prescaler counts 0..F_CLK/F_TICK-1 and wraps.
  - tick is a 1-cycle pulse on the wrap.
- ms_cnt: 16-bit counter, saturating at 0xFFFF. It is cleared on every state transition and incremented on tick.
- FSM states and transitions (press/release takes priority over tick in the same cycle):
  - IDLE:
    - press → PRESS1.
  - PRESS1:
    - release → WAIT2.
    - tick with ms_cnt==LONG_MS-1 → emit LONG, go to HOLD.
  - HOLD:
    - release → IDLE, no event.
    - tick with ms_cnt==REPEAT_MS-1 → emit REPEAT, clear ms_cnt, stay in HOLD.
  - WAIT2:
    - press → PRESS2.
    - tick with ms_cnt==DCLICK_MS-1 → emit SHORT, go to IDLE.
  - PRESS2:
    - release → emit DOUBLE, go to IDLE.
    - No long detection: holding any duration still yields DOUBLE on release.
- Latency:
  - evt_valid rises on the 3rd rising clk edge after key_state changes (2 sync edges + 1 FSM/event register edge).
  - Timed events (SHORT, LONG, REPEAT) register on the clk edge that samples the qualifying tick.
- Event register:
  - Loads when an event is emitted and either the register is empty or evt_valid&evt_ready holds in the same cycle; a handshake plus a new event gives back-to-back valid.
  - evt_valid&evt_ready with no new event: evt_valid=0 and evt_code=0 next cycle.
  - evt_valid=1, evt_ready=0, new event: the new event is dropped, ovf set to 1, and the held event is unchanged.
  - evt_code is stable while evt_valid=1 and evt_ready=0.
- ovf:
  - Set has priority over ovf_clr in the same cycle.
  - Cleared only by ovf_clr or reset.
- Parameter limits: LONG_MS, DCLICK_MS and REPEAT_MS must each be ≥1 and <65536 (elaboration-time assertion). F_CLK/F_TICK must be ≥2.

Decomposition:
- Package key_evt_pkg holds:
  - typedef enum logic [2:0] evt_code_t: EVT_NONE=0, EVT_SHORT=1, EVT_DOUBLE=2, EVT_LONG=3, EVT_REPEAT=4.
  - typedef enum logic [2:0] kstate_t: IDLE, PRESS1, HOLD, WAIT2, PRESS2.
  - localparam MS_CNT_W=16.
- Sub-module ms_tick_gen: parameters F_CLK and F_TICK; ports clk, rst_n, tick. It is reusable by other KeyScan blocks.
- Synchroniser, edge detect, FSM and event register stay inline.

Test Plan:
Bench parameters: F_CLK=1000, F_TICK=100 (tick every 10 clk), LONG_MS=20, DCLICK_MS=5, REPEAT_MS=4, evt_ready=1.
- Press 50 clk, release, idle 200 clk → exactly one SHORT (code 1), asserted 1 cycle, on the 5th tick after the release is detected.
- Press 30, release 20, press 30, release → one DOUBLE (code 2), with evt_valid high on the 3rd clk edge after the final release; no SHORT.
- Hold 400 clk → LONG at tick 20 after press detection, then REPEAT (code 4) every 40 clk: 4 REPEATs by clk 380. Release → no further events, FSM returns to IDLE.
- evt_ready=0, SHORT pending, then generate a LONG → evt_code stays 1 and ovf=1. Raise evt_ready → one handshake, evt_valid=0. Pulse ovf_clr → ovf=0.
- Hold to HOLD state, assert rst_n=0 for 3 clk mid-hold, release the key during reset → outputs all 0 and no event after reset.
- key_state change coincident with a tick during WAIT2 at ms_cnt==4 → the press wins: PRESS2 is entered and no SHORT is emitted.

Source files
------------

// File: rtl/key_evt_pkg.sv
// Shared types for the key gesture decoder: event codes, FSM states and
// the width of the millisecond counter.
package key_evt_pkg;

  localparam int MS_CNT_W = 16;

  typedef enum logic [2:0] {
    EVT_NONE   = 3'd0,
    EVT_SHORT  = 3'd1,
    EVT_DOUBLE = 3'd2,
    EVT_LONG   = 3'd3,
    EVT_REPEAT = 3'd4
  } evt_code_t;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    HOLD,
    WAIT2,
    PRESS2
  } kstate_t;

  function automatic logic is_event(input evt_code_t code);
    return code != EVT_NONE;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler producing a one-cycle tick enable every
// F_CLK/F_TICK clock cycles; shared by the KeyScan timing blocks.
module ms_tick_gen #(
  parameter int F_CLK  = 50000000,
  parameter int F_TICK = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = F_CLK / F_TICK;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("ms_tick_gen: F_CLK/F_TICK must be at least 2");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/key_event_decoder.sv
// Classifies the debounced key level into SHORT / DOUBLE / LONG / REPEAT
// gestures and hands them out one at a time through a valid/ready register.
//
// state  | meaning
// IDLE   | key released, no gesture in progress
// PRESS1 | first press held, timing towards LONG
// HOLD   | LONG issued, key still held, issuing REPEAT periodically
// WAIT2  | first press released, waiting for a second press
// PRESS2 | second press held, DOUBLE goes out on release
module key_event_decoder
  import key_evt_pkg::*;
#(
  parameter int F_CLK     = 50000000,
  parameter int F_TICK    = 1000,
  parameter int LONG_MS   = 1000,
  parameter int DCLICK_MS = 250,
  parameter int REPEAT_MS = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_state,
  input  logic       evt_ready,
  input  logic       ovf_clr,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  output logic       key_pressed,
  output logic       ovf
);

  if (LONG_MS < 1 || LONG_MS > 65535) begin : g_bad_long
    $error("key_event_decoder: LONG_MS out of range");
  end
  if (DCLICK_MS < 1 || DCLICK_MS > 65535) begin : g_bad_dclick
    $error("key_event_decoder: DCLICK_MS out of range");
  end
  if (REPEAT_MS < 1 || REPEAT_MS > 65535) begin : g_bad_repeat
    $error("key_event_decoder: REPEAT_MS out of range");
  end

  localparam logic [MS_CNT_W-1:0] LONG_TC   = MS_CNT_W'(LONG_MS - 1);
  localparam logic [MS_CNT_W-1:0] DCLICK_TC = MS_CNT_W'(DCLICK_MS - 1);
  localparam logic [MS_CNT_W-1:0] REPEAT_TC = MS_CNT_W'(REPEAT_MS - 1);

  // key_state is asynchronous; key_s3 only serves the edge detector
  logic key_s1, key_s2, key_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      key_s3 <= 1'b1;
    end else begin
      key_s1 <= key_state;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
    end
  end

  logic key_press, key_rel;
  assign key_press   = key_s3 & ~key_s2;
  assign key_rel     = ~key_s3 & key_s2;
  assign key_pressed = ~key_s2;

  logic tick;

  ms_tick_gen #(
    .F_CLK  (F_CLK),
    .F_TICK (F_TICK)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  kstate_t              state, state_nxt;
  evt_code_t            emit;
  logic                 cnt_clr;
  logic [MS_CNT_W-1:0]  ms_cnt;

  // key edges are checked before the tick so they win a same-cycle collision
  always_comb begin
    state_nxt = state;
    emit      = EVT_NONE;
    cnt_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (key_press) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (key_rel) begin
          state_nxt = WAIT2;
        end else if (tick && ms_cnt == LONG_TC) begin
          emit      = EVT_LONG;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (key_rel) begin
          state_nxt = IDLE;
        end else if (tick && ms_cnt == REPEAT_TC) begin
          emit    = EVT_REPEAT;
          cnt_clr = 1'b1;
        end
      end
      WAIT2: begin
        if (key_press) begin
          state_nxt = PRESS2;
        end else if (tick && ms_cnt == DCLICK_TC) begin
          emit      = EVT_SHORT;
          state_nxt = IDLE;
        end
      end
      PRESS2: begin
        if (key_rel) begin
          emit      = EVT_DOUBLE;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic emit_v, hshk, drop;
  assign emit_v = is_event(emit);
  assign hshk   = evt_valid & evt_ready;
  assign drop   = emit_v & evt_valid & ~evt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ms_cnt    <= '0;
      evt_valid <= 1'b0;
      evt_code  <= EVT_NONE;
      ovf       <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state || cnt_clr) begin
        ms_cnt <= '0;
      end else if (tick && ms_cnt != {MS_CNT_W{1'b1}}) begin
        ms_cnt <= ms_cnt + MS_CNT_W'(1);
      end

      // a held event is never overwritten; a new one is dropped instead
      if (emit_v && (!evt_valid || evt_ready)) begin
        evt_valid <= 1'b1;
        evt_code  <= emit;
      end else if (hshk) begin
        evt_valid <= 1'b0;
        evt_code  <= EVT_NONE;
      end

      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule
